jk_counter_arst: RTL and testbench

JK_COUNTER_ARST -- requirements
Module: jk_counter_arst

---
 rtl/jk_counter_arst.sv | 97 +++++++++
 tb/tb_jk_counter_arst.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/jk_counter_arst.sv
// WIDTH-stage JK register with up/down counting, parallel load, terminal-count
// detect and a registered wrap pulse; asynchronous active-high reset.
module jk_counter_arst #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter int               SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc,
    output logic             wrap
);

    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;
    localparam logic       SAT_EN    = (SATURATE != 0);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_bar_r;
    logic             wrap_r;
    logic [WIDTH-1:0] q_next_s;
    logic             wrap_next_s;
    logic             tc_s;

    // Terminal count: the next count step would cross the range limit.
    always_comb begin
        tc_s = 1'b0;
        case (mode)
            MODE_UP:   tc_s = (q_r == {WIDTH{1'b1}});
            MODE_DOWN: tc_s = (q_r == {WIDTH{1'b0}});
            default:   tc_s = 1'b0;
        endcase
    end

    // Next-state selection; JK uses the characteristic equation j&~q | ~k&q.
    always_comb begin
        q_next_s = q_r;
        case (mode)
            MODE_JK: q_next_s = (j & ~q_r) | (~k & q_r);
            MODE_UP: begin
                if (tc_s && SAT_EN) begin
                    q_next_s = q_r;
                end else begin
                    q_next_s = q_r + WIDTH'(1);
                end
            end
            MODE_DOWN: begin
                if (tc_s && SAT_EN) begin
                    q_next_s = q_r;
                end else begin
                    q_next_s = q_r - WIDTH'(1);
                end
            end
            MODE_LOAD: q_next_s = load_val;
            default:   q_next_s = q_r;
        endcase
    end

    // A wrap can only happen when counting is allowed to roll over.
    always_comb begin
        if (SAT_EN) begin
            wrap_next_s = 1'b0;
        end else begin
            wrap_next_s = tc_s;
        end
    end

    // State registers; q_bar is stored separately so it never lags q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r     <= RST_VAL;
            q_bar_r <= ~RST_VAL;
            wrap_r  <= 1'b0;
        end else if (en) begin
            q_r     <= q_next_s;
            q_bar_r <= ~q_next_s;
            wrap_r  <= wrap_next_s;
        end else begin
            wrap_r  <= 1'b0;
        end
    end

    assign q     = q_r;
    assign q_bar = q_bar_r;
    assign wrap  = wrap_r;
    assign tc    = tc_s;

endmodule

// File: tb/tb_jk_counter_arst.sv
// Directed bench for jk_counter_arst: three instances (wrapping, saturating,
// non-zero reset value) share one stimulus stream; expectations are hand-computed.
module tb_jk_counter_arst;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] load_val;

    logic [3:0] q0, qb0, q1, qb1, q2, qb2;
    logic       tc0, tc1, tc2, wr0, wr1, wr2;

    int n_checks = 0;
    int n_fails  = 0;

    jk_counter_arst #(.WIDTH(4), .RST_VAL(4'h0), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
        .load_val(load_val), .q(q0), .q_bar(qb0), .tc(tc0), .wrap(wr0)
    );

    jk_counter_arst #(.WIDTH(4), .RST_VAL(4'h0), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
        .load_val(load_val), .q(q1), .q_bar(qb1), .tc(tc1), .wrap(wr1)
    );

    jk_counter_arst #(.WIDTH(4), .RST_VAL(4'h3), .SATURATE(0)) u_rv3 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
        .load_val(load_val), .q(q2), .q_bar(qb2), .tc(tc2), .wrap(wr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; j = 4'h0; k = 4'h0; load_val = 4'h0;
        #2;
        chk("rst_q0", q0, 4'h0);
        chk("rst_qb0", qb0, 4'hF);
        chk("rst_wrap0", {3'b000, wr0}, 4'h0);
        chk("rst_q2", q2, 4'h3);
        chk("rst_qb2", qb2, 4'hC);

        // Edges under reset must be ignored
        en = 1'b1; mode = 2'b11; load_val = 4'h5;
        step();
        step();
        chk("rst_hold_q0", q0, 4'h0);
        chk("rst_hold_q2", q2, 4'h3);

        // Load A, then async reset between edges
        rst = 1'b0; load_val = 4'hA;
        step();
        chk("load_a_q0", q0, 4'hA);
        chk("load_a_qb0", qb0, 4'h5);
        #3 rst = 1'b1;
        #1;
        chk("arst_q0", q0, 4'h0);
        chk("arst_qb0", qb0, 4'hF);
        rst = 1'b0; mode = 2'b01;
        step();
        chk("post_rst_up_q0", q0, 4'h1);
        chk("post_rst_up_q2", q2, 4'h4);

        // JK per-bit
        mode = 2'b11; load_val = 4'h5;
        step();
        mode = 2'b00; j = 4'b1100; k = 4'b1010;
        #1;
        chk("jk_tc0", {3'b000, tc0}, 4'h0);
        step();
        chk("jk_q0", q0, 4'b1101);
        chk("jk_qb0", qb0, 4'b0010);

        // Up-count wrap / saturate
        mode = 2'b11; load_val = 4'hE;
        step();
        mode = 2'b01;
        #1;
        chk("up_tc_e", {3'b000, tc0}, 4'h0);
        step();
        chk("up_q_f", q0, 4'hF);
        chk("up_tc_f", {3'b000, tc0}, 4'h1);
        chk("up_wrap_pre", {3'b000, wr0}, 4'h0);
        step();
        chk("up_q_wrap", q0, 4'h0);
        chk("up_qb_wrap", qb0, 4'hF);
        chk("up_wrap_pulse", {3'b000, wr0}, 4'h1);
        chk("sat_up_q", q1, 4'hF);
        chk("sat_up_wrap", {3'b000, wr1}, 4'h0);
        en = 1'b0;
        step();
        chk("wrap_clear_en0", {3'b000, wr0}, 4'h0);
        chk("hold_q_en0", q0, 4'h0);
        en = 1'b1;
        step();
        chk("up_after_wrap", q0, 4'h1);
        chk("up_wrap_once", {3'b000, wr0}, 4'h0);

        // Down-count saturate
        mode = 2'b11; load_val = 4'h1;
        step();
        mode = 2'b10;
        step();
        chk("sat_dn_q0", q1, 4'h0);
        chk("sat_dn_tc", {3'b000, tc1}, 4'h1);
        step();
        chk("sat_dn_stick", q1, 4'h0);
        chk("sat_dn_qb", qb1, 4'hF);
        chk("sat_dn_wrap", {3'b000, wr1}, 4'h0);
        chk("wrap_dn_q", q0, 4'hF);
        chk("wrap_dn_pulse", {3'b000, wr0}, 4'h1);
        step();
        chk("sat_dn_stick2", q1, 4'h0);
        chk("sat_dn_wrap2", {3'b000, wr1}, 4'h0);
        chk("wrap_dn_q2", q0, 4'hE);

        // Enable hold
        mode = 2'b11; load_val = 4'h7;
        step();
        mode = 2'b01; en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("en_hold_q", q0, 4'h7);
        end
        en = 1'b1;
        step();
        chk("en_resume_q", q0, 4'h8);
        chk("en_resume_qb", qb0, 4'h7);

        // Reset mid-wrap on the RST_VAL=3 instance
        mode = 2'b11; load_val = 4'hF;
        step();
        mode = 2'b01;
        step();
        chk("rv3_wrap_q", q2, 4'h0);
        chk("rv3_wrap_pulse", {3'b000, wr2}, 4'h1);
        #2 rst = 1'b1;
        #1;
        chk("rv3_mid_wrap", {3'b000, wr2}, 4'h0);
        chk("rv3_mid_q", q2, 4'h3);
        chk("rv3_mid_qb", qb2, 4'hC);
        step();
        chk("rv3_rst_hold", q2, 4'h3);
        rst = 1'b0;
        step();
        chk("rv3_first_edge", q2, 4'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
